inst_axi_bridge: RTL and testbench

Instruction-side bridge that converts the fetch stage's SRAM-like request/response port into single-beat AXI read transactions. It sits directly downstream of the fetch stage's instruction-request controller and directly upstream of the top-level AXI master port. It supports one outstanding transaction, with an optional zero-bubble hand-off from R-data to the next accepted request.

---
 rtl/inst_axi_bridge.sv | 116 +++++++++++
 tb/tb_inst_axi_bridge.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_axi_bridge.sv
// Instruction fetch bridge: SRAM-like request/response port to single-beat
// AXI reads, one transaction outstanding, with back-to-back hand-off from R.
module inst_axi_bridge #(
  parameter int          ID_WIDTH = 4,
  parameter int unsigned ARID     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [31:0]         inst_addr,
  input  logic [31:0]         inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [31:0]         inst_rdata,
  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_WIDTH-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R
  } state_t;

  state_t      state;
  state_t      state_n;
  logic        latch;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] hold_q;

  // Writes, response codes and IDs carry no information for this port.
  logic unused_ok;
  assign unused_ok = ^{inst_wr, inst_wdata, rid, rresp, rlast};

  assign arid    = ID_WIDTH'(ARID);
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  always_comb begin
    state_n      = state;
    latch        = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    unique case (state)
      S_IDLE: begin
        inst_addr_ok = inst_req;
        if (inst_req) begin
          latch   = 1'b1;
          state_n = S_AR;
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_n = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid) begin
          inst_data_ok = 1'b1;
          // Accept the next fetch in the same cycle the data returns.
          if (inst_req) begin
            inst_addr_ok = 1'b1;
            latch        = 1'b1;
            state_n      = S_AR;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      addr_q <= 32'd0;
      size_q <= 2'd0;
      hold_q <= 32'd0;
    end else begin
      state <= state_n;
      if (latch) begin
        addr_q <= inst_addr;
        size_q <= inst_size;
      end
      if (inst_data_ok) hold_q <= rdata;
    end
  end

  assign inst_rdata = inst_data_ok ? rdata : hold_q;

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Directed bench for inst_axi_bridge: acts as the AXI slave and checks
// returned words against a queue of expected fetches.
module tb_inst_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int          vectors = 0;
  int          miscompares = 0;
  int          ar_cnt = 0;
  int          ar_base;
  logic [31:0] last_ar = 32'd0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  inst_axi_bridge #(.ID_WIDTH(4), .ARID(0)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h1fc0_0000: return 32'h3c1d_8000;
      32'h1fc0_0020: return 32'hdead_beef;
      default:       return {a[15:0], ~a[15:0]} ^ 32'h0ff0_1234;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Settle combinational outputs, run the scoreboard and AR capture.
  task automatic sample();
    #1;
    if (inst_data_ok) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL spurious_data_ok: observed %h expected none",
               inst_rdata);
      end
      if (exp_q.size() != 0) chk("sb_rdata", inst_rdata, exp_q.pop_front());
    end
    if (inst_addr_ok) exp_q.push_back(mem(inst_addr));
    if (arvalid && arready) begin
      last_ar = araddr;
      ar_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2;
    inst_addr = 32'd0; inst_wdata = 32'hffff_ffff; arready = 1'b0;
    rid = 4'd0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b1;
    rvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    sample();
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_addr_ok", 32'(inst_addr_ok), 32'd0);
    chk("rst_data_ok", 32'(inst_data_ok), 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arsize", 32'(arsize), 32'd0);
    chk("rst_rdata", inst_rdata, 32'd0);
    chk("const_ar", {arlen, 1'b0, arburst, arlock, arcache, arprot, arid,
                     6'd0}, {8'd0, 1'b0, 2'b01, 2'b00, 4'd0, 3'd0, 4'd0,
                     6'd0});
    @(negedge clk);

    // Single fetch, best case
    inst_req = 1'b1; inst_addr = 32'h1fc0_0000; inst_size = 2'd2;
    arready = 1'b1;
    sample();
    chk("t1_addr_ok", 32'(inst_addr_ok), 32'd1);
    @(negedge clk);
    inst_req = 1'b0; inst_addr = 32'h0;
    sample();
    chk("t1_arvalid", 32'(arvalid), 32'd1);
    chk("t1_araddr", araddr, 32'h1fc0_0000);
    chk("t1_arsize", 32'(arsize), 32'd2);
    chk("t1_data_ok_ar", 32'(inst_data_ok), 32'd0);
    @(negedge clk);
    rvalid = 1'b1; rdata = mem(last_ar);
    sample();
    chk("t1_rready", 32'(rready), 32'd1);
    chk("t1_data_ok", 32'(inst_data_ok), 32'd1);
    chk("t1_rdata", inst_rdata, 32'h3c1d_8000);
    @(negedge clk);
    rvalid = 1'b0; rdata = 32'h5555_5555;
    sample();
    chk("t1_idle_arvalid", 32'(arvalid), 32'd0);
    chk("t1_hold", inst_rdata, 32'h3c1d_8000);
    @(negedge clk);

    // AR backpressure with inst_req and address wiggling meanwhile
    inst_req = 1'b1; inst_addr = 32'h1fc0_0010; inst_size = 2'd1;
    arready = 1'b0;
    sample();
    chk("t2_addr_ok", 32'(inst_addr_ok), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      inst_addr = 32'h0bad_0000 + 32'(i); inst_size = 2'd3;
      sample();
      chk("t2_arvalid", 32'(arvalid), 32'd1);
      chk("t2_araddr", araddr, 32'h1fc0_0010);
      chk("t2_arsize", 32'(arsize), 32'd1);
      chk("t2_no_addr_ok", 32'(inst_addr_ok), 32'd0);
      @(negedge clk);
    end
    inst_req = 1'b0; arready = 1'b1;
    sample();
    chk("t2_arvalid_hs", 32'(arvalid), 32'd1);
    @(negedge clk);
    rvalid = 1'b1; rdata = mem(last_ar);
    sample();
    chk("t2_data_ok", 32'(inst_data_ok), 32'd1);
    @(negedge clk);
    rvalid = 1'b0;
    @(negedge clk);

    // Back-to-back fetches
    inst_req = 1'b1; inst_addr = 32'h1fc0_0000; inst_size = 2'd2;
    sample();
    chk("t3_addr_ok0", 32'(inst_addr_ok), 32'd1);
    @(negedge clk);
    inst_addr = 32'h1fc0_0004;
    sample();
    chk("t3_ar_no_addr_ok", 32'(inst_addr_ok), 32'd0);
    @(negedge clk);
    rvalid = 1'b1; rdata = mem(last_ar);
    sample();
    chk("t3_data_ok0", 32'(inst_data_ok), 32'd1);
    chk("t3_addr_ok1", 32'(inst_addr_ok), 32'd1);
    @(negedge clk);
    inst_req = 1'b0; rvalid = 1'b0;
    sample();
    chk("t3_ar1", 32'(arvalid), 32'd1);
    chk("t3_araddr1", araddr, 32'h1fc0_0004);
    chk("t3_gap", 32'(inst_data_ok), 32'd0);
    @(negedge clk);
    rvalid = 1'b1; rdata = mem(last_ar);
    sample();
    chk("t3_data_ok1", 32'(inst_data_ok), 32'd1);
    @(negedge clk);
    rvalid = 1'b0;

    // R delay then hold
    inst_req = 1'b1; inst_addr = 32'h1fc0_0020;
    sample();
    @(negedge clk);
    inst_req = 1'b0;
    sample();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rdata = 32'h1111_1111;
      sample();
      chk("t4_rready", 32'(rready), 32'd1);
      chk("t4_wait", 32'(inst_data_ok), 32'd0);
      chk("t4_prev_hold", inst_rdata, mem(32'h1fc0_0004));
      @(negedge clk);
    end
    rvalid = 1'b1; rdata = mem(last_ar);
    sample();
    chk("t4_data", inst_rdata, 32'hdead_beef);
    @(negedge clk);
    rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rdata = 32'h2222_2222 + 32'(i);
      sample();
      chk("t4_pulse", 32'(inst_data_ok), 32'd0);
      chk("t4_hold", inst_rdata, 32'hdead_beef);
      @(negedge clk);
    end

    // Reset mid-AR
    inst_req = 1'b1; inst_addr = 32'h1fc0_0030; arready = 1'b0;
    sample();
    @(negedge clk);
    inst_req = 1'b0;
    sample();
    chk("t5_arvalid_pre", 32'(arvalid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    sample();
    chk("t5_arvalid", 32'(arvalid), 32'd0);
    chk("t5_rready", 32'(rready), 32'd0);
    chk("t5_araddr", araddr, 32'd0);
    chk("t5_rdata", inst_rdata, 32'd0);
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h1fc0_0040; arready = 1'b1;
    sample();
    chk("t5_addr_ok", 32'(inst_addr_ok), 32'd1);
    @(negedge clk);
    inst_req = 1'b0;
    sample();
    chk("t5_araddr_new", araddr, 32'h1fc0_0040);
    @(negedge clk);
    rvalid = 1'b1; rdata = mem(last_ar);
    sample();
    chk("t5_data_ok", 32'(inst_data_ok), 32'd1);
    @(negedge clk);
    rvalid = 1'b0;

    // Request dropped after acceptance
    ar_base = ar_cnt;
    inst_req = 1'b1; inst_addr = 32'h1fc0_0050; arready = 1'b0;
    sample();
    @(negedge clk);
    inst_req = 1'b0;
    sample();
    @(negedge clk);
    arready = 1'b1;
    sample();
    @(negedge clk);
    arready = 1'b0;
    sample();
    chk("t6_r_wait", 32'(inst_data_ok), 32'd0);
    @(negedge clk);
    rvalid = 1'b1; rdata = mem(last_ar);
    sample();
    chk("t6_data_ok", 32'(inst_data_ok), 32'd1);
    @(negedge clk);
    rvalid = 1'b0; arready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("t6_no_ar", 32'(arvalid), 32'd0);
      @(negedge clk);
    end
    chk("t6_ar_count", 32'(ar_cnt - ar_base), 32'd1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
